id_stage: RTL and testbench

//  Decode stage of the 5-stage RV32I pipeline; consumes PC_IF/INSTRUCTION_IF from the fetch stage.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/id_stage_if.sv | 42 ++++
 rtl/id_stage_reg_file.sv | 37 +++
 rtl/id_stage.sv | 60 ++++++
 tb/tb_id_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the immediate generator used by the decode stage.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int REG_W = 5;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] i);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{i[31]}}, i[31:20]};
      OP_STORE:                 imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {i[31:12], 12'b0};
      OP_JAL:                   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle between the decode stage and its neighbours (fetch, EX, WB, ID/EX register).
interface id_stage_if;
  import riscv_pkg::*;

  // Flow control: no valid/ready pair. PC_write=0 tells fetch to hold its PC and
  // present the same instruction next cycle; BUBBLE_ID=1 tells ID/EX to insert a
  // bubble that same cycle. PCSrc=1 discards whatever sits in IF/ID.
  logic              PCSrc;
  logic [XLEN-1:0]   PC_IF;
  logic [XLEN-1:0]   INSTRUCTION_IF;
  logic              MemRead_EX;
  logic [REG_W-1:0]  rd_EX;
  logic              RegWrite_WB;
  logic [REG_W-1:0]  rd_WB;
  logic [XLEN-1:0]   DATA_WB;

  logic              PC_write;
  logic              BUBBLE_ID;
  logic [XLEN-1:0]   PC_ID;
  logic [XLEN-1:0]   INSTRUCTION_ID;
  logic [REG_W-1:0]  RS1_ID;
  logic [REG_W-1:0]  RS2_ID;
  logic [REG_W-1:0]  RD_ID;
  logic [2:0]        FUNCT3_ID;
  logic [6:0]        FUNCT7_ID;
  logic [6:0]        OPCODE_ID;
  logic [XLEN-1:0]   REG_DATA1_ID;
  logic [XLEN-1:0]   REG_DATA2_ID;
  logic [XLEN-1:0]   IMM_ID;

  modport master (
    output PCSrc, PC_IF, INSTRUCTION_IF, MemRead_EX, rd_EX, RegWrite_WB, rd_WB, DATA_WB,
    input  PC_write, BUBBLE_ID, PC_ID, INSTRUCTION_ID, RS1_ID, RS2_ID, RD_ID,
           FUNCT3_ID, FUNCT7_ID, OPCODE_ID, REG_DATA1_ID, REG_DATA2_ID, IMM_ID
  );

  modport slave (
    input  PCSrc, PC_IF, INSTRUCTION_IF, MemRead_EX, rd_EX, RegWrite_WB, rd_WB, DATA_WB,
    output PC_write, BUBBLE_ID, PC_ID, INSTRUCTION_ID, RS1_ID, RS2_ID, RD_ID,
           FUNCT3_ID, FUNCT7_ID, OPCODE_ID, REG_DATA1_ID, REG_DATA2_ID, IMM_ID
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two combinational reads, one synchronous write, write-through bypass.
module reg_file
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [REG_W-1:0] raddr1,
  input  logic [REG_W-1:0] raddr2,
  output logic [XLEN-1:0]  rdata1,
  output logic [XLEN-1:0]  rdata2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets an instruction in ID see the value being written back this cycle.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (wr_en && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (wr_en && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register file, immediate generation, load-use stall.
module id_stage
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  id_stage_if.slave bus
);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  insn_q;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             stall;

  // Flush beats stall so a taken branch never keeps a wrong-path instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      insn_q <= NOP_INSN;
    end else if (bus.PCSrc) begin
      pc_q   <= '0;
      insn_q <= NOP_INSN;
    end else if (!stall) begin
      pc_q   <= bus.PC_IF;
      insn_q <= bus.INSTRUCTION_IF;
    end
  end

  assign rs1 = insn_q[19:15];
  assign rs2 = insn_q[24:20];

  assign stall = bus.MemRead_EX && (bus.rd_EX != '0) &&
                 ((bus.rd_EX == rs1) || (bus.rd_EX == rs2));

  assign bus.PC_write       = ~stall;
  assign bus.BUBBLE_ID      = stall;
  assign bus.PC_ID          = pc_q;
  assign bus.INSTRUCTION_ID = insn_q;
  assign bus.RS1_ID         = rs1;
  assign bus.RS2_ID         = rs2;
  assign bus.RD_ID          = insn_q[11:7];
  assign bus.FUNCT3_ID      = insn_q[14:12];
  assign bus.FUNCT7_ID      = insn_q[31:25];
  assign bus.OPCODE_ID      = insn_q[6:0];
  assign bus.IMM_ID         = gen_imm(insn_q);

  reg_file u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.RegWrite_WB),
    .waddr  (bus.rd_WB),
    .wdata  (bus.DATA_WB),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (bus.REG_DATA1_ID),
    .rdata2 (bus.REG_DATA2_ID)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for the decode stage: inputs change on negedge, outputs sampled 1ns later.
module tb_id_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [63:0] exp_q[$];

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_if(input logic [31:0] pc, input logic [31:0] insn);
    bus.PC_IF          = pc;
    bus.INSTRUCTION_IF = insn;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.RegWrite_WB = we;
    bus.rd_WB       = rd;
    bus.DATA_WB     = data;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.PC_ID !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", bus.PC_ID, 32'h0); end
    n_checks++; if (bus.INSTRUCTION_ID !== 32'h13) begin n_fail++; $display("FAIL reset_insn got %h exp %h", bus.INSTRUCTION_ID, 32'h13); end
    n_checks++; if (bus.PC_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write got %b exp 1", bus.PC_write); end
    n_checks++; if (bus.BUBBLE_ID !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b exp 0", bus.BUBBLE_ID); end
    n_checks++; if (bus.IMM_ID !== 32'h0) begin n_fail++; $display("FAIL reset_imm got %h exp 0", bus.IMM_ID); end
    n_checks++; if (bus.REG_DATA1_ID !== 32'h0 || bus.REG_DATA2_ID !== 32'h0) begin
      n_fail++; $display("FAIL reset_regdata got %h/%h exp 0/0", bus.REG_DATA1_ID, bus.REG_DATA2_ID);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk); drive_if(32'h10, 32'h0050_0093);
    @(negedge clk); #1;
    n_checks++; if (bus.PC_ID !== 32'h10) begin n_fail++; $display("FAIL fetch_pc got %h exp %h", bus.PC_ID, 32'h10); end
    n_checks++; if (bus.RD_ID !== 5'd1) begin n_fail++; $display("FAIL fetch_rd got %0d exp 1", bus.RD_ID); end
    n_checks++; if (bus.IMM_ID !== 32'h5) begin n_fail++; $display("FAIL fetch_imm got %h exp 5", bus.IMM_ID); end
    n_checks++; if (bus.OPCODE_ID !== 7'h13 || bus.FUNCT3_ID !== 3'd0 || bus.RS1_ID !== 5'd0) begin
      n_fail++; $display("FAIL fetch_fields got op %h f3 %h rs1 %0d exp 13/0/0", bus.OPCODE_ID, bus.FUNCT3_ID, bus.RS1_ID);
    end
  endtask

  task automatic test_regfile();
    // add x5,x3,x4
    drive_if(32'h14, 32'h0041_82B3);
    @(negedge clk);
    drive_wb(1'b1, 5'd3, 32'hDEAD_BEEF); #1;
    n_checks++; if (bus.REG_DATA1_ID !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rf_bypass1 got %h exp %h", bus.REG_DATA1_ID, 32'hDEADBEEF); end
    n_checks++; if (bus.REG_DATA2_ID !== 32'h0) begin n_fail++; $display("FAIL rf_other_port got %h exp 0", bus.REG_DATA2_ID); end
    @(negedge clk);
    drive_wb(1'b1, 5'd4, 32'h0000_00A5); #1;
    n_checks++; if (bus.REG_DATA1_ID !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rf_stored1 got %h exp %h", bus.REG_DATA1_ID, 32'hDEADBEEF); end
    n_checks++; if (bus.REG_DATA2_ID !== 32'hA5) begin n_fail++; $display("FAIL rf_bypass2 got %h exp a5", bus.REG_DATA2_ID); end
    // addi x1,x0,5 reads x0; attempt to write x0
    drive_if(32'h18, 32'h0050_0093);
    @(negedge clk);
    drive_wb(1'b1, 5'd0, 32'h1234_5678); #1;
    n_checks++; if (bus.REG_DATA1_ID !== 32'h0) begin n_fail++; $display("FAIL rf_x0_bypass got %h exp 0", bus.REG_DATA1_ID); end
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0); #1;
    n_checks++; if (bus.REG_DATA1_ID !== 32'h0) begin n_fail++; $display("FAIL rf_x0_write got %h exp 0", bus.REG_DATA1_ID); end
  endtask

  task automatic test_load_use();
    drive_if(32'h20, 32'h0031_0233); // add x4,x2,x3
    @(negedge clk);
    drive_if(32'h24, 32'h0050_0093);
    bus.MemRead_EX = 1'b0; bus.rd_EX = 5'd2; #1;
    n_checks++; if (bus.PC_write !== 1'b1) begin n_fail++; $display("FAIL lu_no_load got %b exp 1", bus.PC_write); end
    bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd0; #1;
    n_checks++; if (bus.BUBBLE_ID !== 1'b0) begin n_fail++; $display("FAIL lu_rd_x0 got %b exp 0", bus.BUBBLE_ID); end
    bus.rd_EX = 5'd7; #1;
    n_checks++; if (bus.PC_write !== 1'b1) begin n_fail++; $display("FAIL lu_no_match got %b exp 1", bus.PC_write); end
    bus.rd_EX = 5'd3; #1;
    n_checks++; if (bus.BUBBLE_ID !== 1'b1) begin n_fail++; $display("FAIL lu_rs2_match got %b exp 1", bus.BUBBLE_ID); end
    bus.rd_EX = 5'd2; #1;
    n_checks++; if (bus.PC_write !== 1'b0 || bus.BUBBLE_ID !== 1'b1) begin
      n_fail++; $display("FAIL lu_rs1_match got pcw %b bubble %b exp 0/1", bus.PC_write, bus.BUBBLE_ID);
    end
    @(negedge clk); #1;
    n_checks++; if (bus.PC_ID !== 32'h20 || bus.INSTRUCTION_ID !== 32'h0031_0233) begin
      n_fail++; $display("FAIL lu_hold got %h/%h exp 20/00310233", bus.PC_ID, bus.INSTRUCTION_ID);
    end
    bus.MemRead_EX = 1'b0; #1;
    n_checks++; if (bus.PC_write !== 1'b1) begin n_fail++; $display("FAIL lu_release got %b exp 1", bus.PC_write); end
    @(negedge clk); #1;
    n_checks++; if (bus.PC_ID !== 32'h24) begin n_fail++; $display("FAIL lu_advance got %h exp 24", bus.PC_ID); end
  endtask

  task automatic test_flush();
    drive_if(32'h40, 32'h0050_0093);
    bus.PCSrc = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus.INSTRUCTION_ID !== 32'h13 || bus.PC_ID !== 32'h0) begin
      n_fail++; $display("FAIL flush got %h/%h exp 0/00000013", bus.PC_ID, bus.INSTRUCTION_ID);
    end
    bus.PCSrc = 1'b0;
  endtask

  task automatic test_imm();
    logic [31:0] insns [7];
    logic [31:0] imms  [7];
    insns = '{32'hFE00_0EE3, 32'h1234_50B7, 32'hFE51_2C23, 32'h0010_00EF,
              32'h0031_0233, 32'hFFF0_0093, 32'h8000_0117};
    imms  = '{32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFF8, 32'h0000_0800,
              32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < 7; i++) begin
      drive_if(32'h100 + 32'(i * 4), insns[i]);
      @(negedge clk); #1;
      n_checks++; if (bus.IMM_ID !== imms[i]) begin
        n_fail++; $display("FAIL imm_%0d insn %h got %h exp %h", i, insns[i], bus.IMM_ID, imms[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (i > 0) begin
        exp = exp_q.pop_front();
        n_checks++; if ({bus.PC_ID, bus.INSTRUCTION_ID} !== exp) begin
          n_fail++; $display("FAIL b2b_%0d got %h/%h exp %h/%h", i, bus.PC_ID, bus.INSTRUCTION_ID, exp[63:32], exp[31:0]);
        end
      end
      drive_if(32'h200 + 32'(i * 4), 32'h0000_0093 | (32'(i) << 20));
      exp_q.push_back({32'h200 + 32'(i * 4), 32'h0000_0093 | (32'(i) << 20)});
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    drive_if(32'h300, 32'h0031_0233); // add x4,x2,x3
    @(negedge clk);
    bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd2; #1;
    n_checks++; if (bus.PC_write !== 1'b0) begin n_fail++; $display("FAIL rs_stall got %b exp 0", bus.PC_write); end
    reset = 1'b0; #1;
    n_checks++; if (bus.PC_ID !== 32'h0 || bus.INSTRUCTION_ID !== 32'h13 || bus.PC_write !== 1'b1) begin
      n_fail++; $display("FAIL rs_clear got %h/%h pcw %b exp 0/00000013/1", bus.PC_ID, bus.INSTRUCTION_ID, bus.PC_write);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.MemRead_EX = 1'b0;
    drive_if(32'h304, 32'h0041_82B3); // add x5,x3,x4
    @(negedge clk); #1;
    n_checks++; if (bus.REG_DATA1_ID !== 32'h0 || bus.REG_DATA2_ID !== 32'h0) begin
      n_fail++; $display("FAIL rs_regs got %h/%h exp 0/0", bus.REG_DATA1_ID, bus.REG_DATA2_ID);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.PCSrc = 1'b0;
    bus.MemRead_EX = 1'b0;
    bus.rd_EX = 5'd0;
    drive_if(32'h0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_fetch();
    test_regfile();
    test_load_use();
    test_flush();
    test_imm();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
